// File: rtl/uart_rx_deserializer.sv
// UART receiver (8N1, LSB first): 2-flop synchronizer, start-glitch rejection,
// 3-tap majority vote per bit, framing-error/break detection, single-cycle outputs.
module uart_rx_deserializer #(
   parameter int CLKS_PER_BIT = 217
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       uart_rxd,
   output logic       rx_en,
   output logic [7:0] rx_data,
   output logic       rx_framing_err,
   output logic       rx_busy
);

   localparam int CW   = $clog2(CLKS_PER_BIT);
   localparam int HALF = CLKS_PER_BIT / 2;

   localparam logic [CW-1:0] TAP_A  = CW'(HALF - 1);
   localparam logic [CW-1:0] TAP_B  = CW'(HALF);
   localparam logic [CW-1:0] DECIDE = CW'(HALF + 1);
   localparam logic [CW-1:0] LAST   = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_t;

   state_t        state;
   state_t        next_state;
   logic          sync_1;
   logic          rxd_s;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_idx;
   logic [1:0]    taps;
   logic [7:0]    shift_reg;

   logic at_decide;
   logic at_wrap;
   logic majority;
   logic shift_en;
   logic byte_done;
   logic frame_bad;

   // Both synchronizer flops come out of reset at the idle (high) line level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_1 <= 1'b1;
         rxd_s  <= 1'b1;
      end else begin
         sync_1 <= uart_rxd;
         rxd_s  <= sync_1;
      end
   end

   assign at_decide = (cnt == DECIDE);
   assign at_wrap   = (cnt == LAST);
   assign majority  = (taps[0] & taps[1]) | (taps[0] & rxd_s) | (taps[1] & rxd_s);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // STOP leaves at the decision point rather than the wrap so the receiver
   // re-arms half a bit early and can catch an immediately following start bit.
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:  if (!rxd_s) next_state = S_START;
         S_START: begin
            if (at_decide && majority) next_state = S_IDLE;
            else if (at_wrap)          next_state = S_DATA;
         end
         S_DATA:  if (at_wrap && bit_idx == 3'd7) next_state = S_STOP;
         S_STOP:  if (at_decide) next_state = majority ? S_IDLE : S_BREAK;
         S_BREAK: if (rxd_s) next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   always_comb begin
      rx_busy   = (state != S_IDLE);
      shift_en  = (state == S_DATA) && at_decide;
      byte_done = (state == S_STOP) && at_decide && majority;
      frame_bad = (state == S_STOP) && at_decide && !majority;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt            <= '0;
         bit_idx        <= 3'd0;
         taps           <= 2'b00;
         shift_reg      <= 8'h00;
         rx_en          <= 1'b0;
         rx_data        <= 8'h00;
         rx_framing_err <= 1'b0;
      end else begin
         if (state == S_IDLE || next_state != state || at_wrap) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end

         if (cnt == TAP_A) taps[0] <= rxd_s;
         if (cnt == TAP_B) taps[1] <= rxd_s;

         if (state == S_IDLE) begin
            bit_idx <= 3'd0;
         end else if (state == S_DATA && at_wrap) begin
            bit_idx <= bit_idx + 3'd1;
         end

         // Line order is LSB first, so each new bit enters at the MSB.
         if (shift_en) shift_reg <= {majority, shift_reg[7:1]};

         rx_en          <= byte_done;
         rx_framing_err <= frame_bad;
         if (byte_done) rx_data <= shift_reg;
      end
   end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Self-checking bench for uart_rx_deserializer: serial frames are generated at
// configurable baud error and checked against a queue of expected received events.
module tb_uart_rx_deserializer;

   localparam int CPB  = 217;
   localparam int HALF = CPB / 2;
   localparam int LAT  = 2 + CPB * 9 + HALF + 1 + 1;

   typedef struct {
      bit         is_err;
      logic [7:0] data;
      longint     t_lo;
      longint     t_hi;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       uart_rxd = 1'b1;
   logic       rx_en;
   logic [7:0] rx_data;
   logic       rx_framing_err;
   logic       rx_busy;

   longint     cyc = 0;
   int         total = 0;
   int         bad = 0;
   int         en_count = 0;
   int         err_count = 0;
   logic [7:0] last_data = 8'h00;
   ev_t        exp_q[$];

   uart_rx_deserializer #(.CLKS_PER_BIT(CPB)) dut (
      .clk            (clk),
      .rst            (rst),
      .uart_rxd       (uart_rxd),
      .rx_en          (rx_en),
      .rx_data        (rx_data),
      .rx_framing_err (rx_framing_err),
      .rx_busy        (rx_busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h want %0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   task automatic idleCycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // One 8N1 frame at pct% of nominal baud; optional 1-cycle spike mid data bit,
   // optional reset assertion half way into line bit abort_bit (frame is then dropped).
   task automatic applyStimulus(input logic [7:0] data, input int pct, input bit spike,
                                input bit stop_val, input int abort_bit);
      int     cpb_x100;
      int     frame_len;
      longint t0;
      ev_t    e;
      cpb_x100  = (CPB * 10000) / pct;
      frame_len = (10 * cpb_x100) / 100;
      t0        = cyc;
      if (abort_bit < 0) begin
         e.is_err = (stop_val == 1'b0);
         e.data   = data;
         e.t_lo   = t0 + LAT - 1;
         e.t_hi   = t0 + LAT + 1;
         exp_q.push_back(e);
      end
      for (int c = 0; c < frame_len; c++) begin
         int   b;
         logic v;
         b = (c * 100) / cpb_x100;
         if (b == 0)      v = 1'b0;
         else if (b <= 8) v = data[b-1];
         else             v = stop_val;
         if (spike && b >= 1 && b <= 8 && c == (b * cpb_x100 + cpb_x100 / 2) / 100) v = ~v;
         if (abort_bit >= 0 && b == abort_bit && c == (b * cpb_x100) / 100 + cpb_x100 / 200) begin
            rst = 1'b1;
            #1;
            checkOutput("async_reset_outputs", {rx_en, rx_framing_err, rx_busy, rx_data}, 32'h0);
            uart_rxd = 1'b1;
            idleCycles(5);
            checkOutput("held_reset_outputs", {rx_en, rx_framing_err, rx_busy, rx_data}, 32'h0);
            rst = 1'b0;
            return;
         end
         uart_rxd = v;
         idleCycles(1);
      end
   endtask

   task automatic drainExpected();
      for (int i = 0; i < 3000 && exp_q.size() > 0; i++) idleCycles(1);
      checkOutput("drain_pending_events", exp_q.size(), 0);
      idleCycles(2);
   endtask

   // Compare process: every received event must match the head of the expected queue.
   initial begin : compare
      ev_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            checkOutput("reset_outputs", {rx_en, rx_framing_err, rx_busy, rx_data}, 32'h0);
            last_data = 8'h00;
         end else if (rx_en || rx_framing_err) begin
            if (rx_en) en_count++;
            if (rx_framing_err) err_count++;
            checkOutput("pulse_exclusive", {31'h0, rx_en & rx_framing_err}, 32'h0);
            if (exp_q.size() == 0) begin
               checkOutput("unexpected_pulse", {30'h0, rx_en, rx_framing_err}, 32'h0);
            end else begin
               e = exp_q.pop_front();
               checkOutput("event_kind", {31'h0, rx_framing_err}, {31'h0, e.is_err});
               total++;
               if (cyc < e.t_lo || cyc > e.t_hi) begin
                  bad++;
                  $display("[TB] FAIL latency: got cycle %0d want %0d..%0d", cyc, e.t_lo, e.t_hi);
               end
               if (rx_en) begin
                  checkOutput("rx_data", rx_data, e.data);
                  checkOutput("busy_low_on_en", rx_busy, 1'b0);
                  last_data = e.data;
               end else begin
                  checkOutput("data_kept_on_err", rx_data, last_data);
               end
            end
         end else begin
            checkOutput("data_stable", rx_data, last_data);
            if (exp_q.size() > 0 && cyc > exp_q[0].t_hi) begin
               total++;
               bad++;
               $display("[TB] FAIL pulse_timeout: got none want event by cycle %0d", exp_q[0].t_hi);
               void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin : main
      int en0;
      int err0;
      int busy_n;
      #1;
      checkOutput("reset_state", {rx_en, rx_framing_err, rx_busy, rx_data}, 32'h0);
      idleCycles(4);
      @(posedge clk);
      #1;
      rst = 1'b0;
      idleCycles(20);
      checkOutput("idle_after_reset", {rx_en, rx_framing_err, rx_busy, rx_data}, 32'h0);

      $display("[TB] single byte 0x55");
      en0 = en_count; err0 = err_count;
      applyStimulus(8'h55, 100, 1'b0, 1'b1, -1);
      idleCycles(200);
      drainExpected();
      checkOutput("t1_data", rx_data, 8'h55);
      checkOutput("t1_en_count", en_count - en0, 1);
      checkOutput("t1_err_count", err_count - err0, 0);
      checkOutput("t1_busy", rx_busy, 1'b0);

      $display("[TB] back-to-back 0x00 0xFF 0xA5");
      en0 = en_count;
      applyStimulus(8'h00, 100, 1'b0, 1'b1, -1);
      applyStimulus(8'hFF, 100, 1'b0, 1'b1, -1);
      applyStimulus(8'hA5, 100, 1'b0, 1'b1, -1);
      idleCycles(50);
      drainExpected();
      checkOutput("t2_data", rx_data, 8'hA5);
      checkOutput("t2_en_count", en_count - en0, 3);

      $display("[TB] start-bit glitch");
      en0 = en_count; err0 = err_count; busy_n = 0;
      for (int i = 0; i < 300; i++) begin
         uart_rxd = (i < 50) ? 1'b0 : 1'b1;
         idleCycles(1);
         if (rx_busy) busy_n++;
      end
      checkOutput("t3_busy_bounded", {31'h0, (busy_n > 0 && busy_n <= HALF + 4)}, 32'h1);
      checkOutput("t3_no_pulses", (en_count - en0) + (err_count - err0), 0);
      applyStimulus(8'h3C, 100, 1'b0, 1'b1, -1);
      idleCycles(50);
      drainExpected();
      checkOutput("t3_data", rx_data, 8'h3C);

      $display("[TB] framing error and break");
      en0 = en_count; err0 = err_count;
      applyStimulus(8'hA5, 100, 1'b0, 1'b0, -1);
      uart_rxd = 1'b0;
      idleCycles(3 * 10 * CPB);
      checkOutput("t4_err_count", err_count - err0, 1);
      checkOutput("t4_en_count", en_count - en0, 0);
      checkOutput("t4_busy_in_break", rx_busy, 1'b1);
      uart_rxd = 1'b1;
      idleCycles(300);
      checkOutput("t4_busy_after_break", rx_busy, 1'b0);
      applyStimulus(8'h3C, 100, 1'b0, 1'b1, -1);
      idleCycles(50);
      drainExpected();
      checkOutput("t4_data", rx_data, 8'h3C);
      checkOutput("t4_err_total", err_count - err0, 1);

      $display("[TB] baud error with mid-bit spikes");
      applyStimulus(8'h96, 97, 1'b1, 1'b1, -1);
      idleCycles(100);
      drainExpected();
      checkOutput("t5_slow_data", rx_data, 8'h96);
      applyStimulus(8'h96, 103, 1'b1, 1'b1, -1);
      idleCycles(100);
      drainExpected();
      checkOutput("t5_fast_data", rx_data, 8'h96);

      $display("[TB] reset during data bit 4");
      en0 = en_count; err0 = err_count;
      applyStimulus(8'h5A, 100, 1'b0, 1'b1, 5);
      idleCycles(3 * CPB);
      checkOutput("t6_no_pulse", (en_count - en0) + (err_count - err0), 0);
      checkOutput("t6_outputs_after", {rx_en, rx_framing_err, rx_busy, rx_data}, 32'h0);
      applyStimulus(8'hC3, 100, 1'b0, 1'b1, -1);
      idleCycles(50);
      drainExpected();
      checkOutput("t6_data", rx_data, 8'hC3);

      $display("[TB] randomized frames");
      for (int n = 0; n < 12; n++) begin
         applyStimulus(8'($urandom), $urandom_range(97, 103), 1'($urandom_range(0, 1)), 1'b1, -1);
         idleCycles($urandom_range(0, 300));
      end
      idleCycles(50);
      drainExpected();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
